// File: rtl/gemm_tile_controller.sv
// Tile-loop sequencer (m outer, n, k inner) for a TileM x TileN x TileK MAC array.
// Optional perf counters: define GEMM_TILE_CTRL_PERF_EN.
module gemm_tile_controller #(
  parameter int AddrWidth = 16,
  parameter int TileM     = 4,
  parameter int TileN     = 16,
  parameter int TileK     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] K_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic                 input_valid_i,
  output logic                 input_ready_o,
  output logic                 acc_clear_o,
  output logic [AddrWidth-1:0] M_count_o,
  output logic [AddrWidth-1:0] K_count_o,
  output logic [AddrWidth-1:0] N_count_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [AddrWidth-1:0] result_m_o,
  output logic [AddrWidth-1:0] result_n_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_stalls_o
);
  localparam int MShift = $clog2(TileM);
  localparam int NShift = $clog2(TileN);
  localparam int KShift = $clog2(TileK);
  localparam logic [AddrWidth-1:0] MMask = AddrWidth'(TileM - 1);
  localparam logic [AddrWidth-1:0] NMask = AddrWidth'(TileN - 1);
  localparam logic [AddrWidth-1:0] KMask = AddrWidth'(TileK - 1);
  localparam logic [AddrWidth-1:0] One   = AddrWidth'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e               state_r, state_s;
  logic [AddrWidth-1:0] m_r, n_r, k_r;
  logic [AddrWidth-1:0] m_last_r, n_last_r, k_last_r;
  logic [AddrWidth-1:0] res_m_r, res_n_r;
  logic                 pending_r, done_r, error_r, err_flag_r;
  logic                 sizes_ok_s, start_s, step_s, res_take_s;
  logic                 k_wrap_s, n_wrap_s, m_wrap_s, last_step_s;

  assign sizes_ok_s  = (M_size_i != '0) && ((M_size_i & MMask) == '0) &&
                       (N_size_i != '0) && ((N_size_i & NMask) == '0) &&
                       (K_size_i != '0) && ((K_size_i & KMask) == '0);
  assign start_s     = (state_r == IDLE) && start_i;
  assign input_ready_o = (state_r == BUSY) && !(pending_r && !result_ready_i);
  assign step_s      = input_valid_i && input_ready_o;
  assign acc_clear_o = step_s && (k_r == '0);
  assign res_take_s  = pending_r && result_ready_i;
  assign k_wrap_s    = (k_r == k_last_r);
  assign n_wrap_s    = (n_r == n_last_r);
  assign m_wrap_s    = (m_r == m_last_r);
  assign last_step_s = step_s && k_wrap_s && n_wrap_s && m_wrap_s;

  assign M_count_o      = m_r;
  assign N_count_o      = n_r;
  assign K_count_o      = k_r;
  assign result_valid_o = pending_r;
  assign result_m_o     = res_m_r;
  assign result_n_o     = res_n_r;
  assign busy_o         = (state_r != IDLE);
  assign done_o         = done_r;
  assign error_o        = error_r;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Next-state logic; an invalid start goes straight to FINISH with no steps.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = sizes_ok_s ? BUSY : FINISH;
        else         state_s = IDLE;
      end
      BUSY: begin
        if (last_step_s) state_s = DRAIN;
        else             state_s = BUSY;
      end
      DRAIN: begin
        if (!pending_r || res_take_s) state_s = FINISH;
        else                          state_s = DRAIN;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Tile totals (stored as last index) and error flag captured on start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_last_r   <= '0;
      n_last_r   <= '0;
      k_last_r   <= '0;
      err_flag_r <= 1'b0;
    end else if (start_s) begin
      err_flag_r <= !sizes_ok_s;
      if (sizes_ok_s) begin
        m_last_r <= (M_size_i >> MShift) - One;
        n_last_r <= (N_size_i >> NShift) - One;
        k_last_r <= (K_size_i >> KShift) - One;
      end
    end
  end

  // Loop-nest counters: k innermost, then n, then m.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_r <= '0;
      n_r <= '0;
      k_r <= '0;
    end else if (state_r == FINISH) begin
      m_r <= '0;
      n_r <= '0;
      k_r <= '0;
    end else if (step_s) begin
      if (k_wrap_s) begin
        k_r <= '0;
        if (n_wrap_s) begin
          n_r <= '0;
          m_r <= m_wrap_s ? '0 : m_r + One;
        end else begin
          n_r <= n_r + One;
        end
      end else begin
        k_r <= k_r + One;
      end
    end
  end

  // Result hold register; a new completion in the same cycle as a take wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_r <= 1'b0;
      res_m_r   <= '0;
      res_n_r   <= '0;
    end else if (step_s && k_wrap_s) begin
      pending_r <= 1'b1;
      res_m_r   <= m_r;
      res_n_r   <= n_r;
    end else if (res_take_s) begin
      pending_r <= 1'b0;
    end
  end

  // Completion and error pulses, one cycle after FINISH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      done_r  <= (state_r == FINISH);
      error_r <= (state_r == FINISH) && err_flag_r;
    end
  end

`ifdef GEMM_TILE_CTRL_PERF_EN
  logic [31:0] perf_cycles_r, perf_stalls_r;

  // Saturating busy-cycle and input-stall counters, cleared on start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_r <= '0;
      perf_stalls_r <= '0;
    end else if (start_s) begin
      perf_cycles_r <= '0;
      perf_stalls_r <= '0;
    end else begin
      if (busy_o && (perf_cycles_r != '1))
        perf_cycles_r <= perf_cycles_r + 32'd1;
      if ((state_r == BUSY) && input_valid_i && !input_ready_o && (perf_stalls_r != '1))
        perf_stalls_r <= perf_stalls_r + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cycles_r;
  assign perf_stalls_o = perf_stalls_r;
`else
  assign perf_cycles_o = 32'd0;
  assign perf_stalls_o = 32'd0;
`endif

endmodule
